// File: rtl/rr_req_queue_bank.sv
// rr_req_queue_bank
//   Requester-side endpoint for a round-robin arbiter. N per-source FIFOs present
//   a request vector (FIFO non-empty) and the arbiter's grant index pops the
//   granted FIFO's head onto a single registered output.
//
// Parameters
//   N      number of sources / FIFOs (>= 2)
//   W      data width per entry
//   DEPTH  entries per FIFO (power of 2, >= 2)
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   in_vld[N]         per-source push request
//   in_data[N*W]      per-source data, slice i = in_data[i*W +: W]
//   in_rdy[N]         per-source FIFO not full (registered state only)
//   req[N]            FIFO i non-empty (registered state only)
//   gnt_idx, gnt_vld  grant from the arbiter
//   out_vld           one-cycle pulse per pop
//   out_data, out_src popped entry and the FIFO it came from (hold when idle)
//
// Build option
//   REQ_GNT_ERR_EN    adds gnt_err (pulse) and gnt_err_sticky (cleared by rst
//                     only), flagging grants to an empty or nonexistent FIFO.
module rr_req_queue_bank #(
    parameter int unsigned N     = 4,
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         in_vld,
    input  logic [N*W-1:0]       in_data,
    output logic [N-1:0]         in_rdy,
    output logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] gnt_idx,
    input  logic                 gnt_vld,
`ifdef REQ_GNT_ERR_EN
    output logic                 gnt_err,
    output logic                 gnt_err_sticky,
`endif
    output logic                 out_vld,
    output logic [W-1:0]         out_data,
    output logic [$clog2(N)-1:0] out_src
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  r_mem  [N][DEPTH];
    logic [AW-1:0] r_wptr [N];
    logic [AW-1:0] r_rptr [N];
    logic [CW-1:0] r_cnt  [N];

    logic [N-1:0]  w_push;
    logic [N-1:0]  w_pop;
    logic          w_pop_any;
    logic [W-1:0]  w_head;

    logic          r_out_vld;
    logic [W-1:0]  r_out_data;
    logic [IW-1:0] r_out_src;

    // Pop decode compares gnt_idx against each legal index, so an index >= N or
    // a grant to an empty FIFO simply matches nothing.
    always_comb begin
        in_rdy    = '0;
        req       = '0;
        w_push    = '0;
        w_pop     = '0;
        w_head    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_rdy[i] = (r_cnt[i] != CW'(DEPTH));
            req[i]    = (r_cnt[i] != '0);
            w_push[i] = in_vld[i] && in_rdy[i];
            w_pop[i]  = gnt_vld && (gnt_idx == IW'(i)) && req[i];
            if (w_pop[i]) begin
                w_head = r_mem[i][r_rptr[i]];
            end
        end
        w_pop_any = |w_pop;
    end

    // Storage array is not reset; pointers and counts define validity.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < N; i++) begin
            if (w_push[i]) begin
                r_mem[i][r_wptr[i]] <= in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (w_push[i]) begin
                    r_wptr[i] <= r_wptr[i] + AW'(1);
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= r_rptr[i] + AW'(1);
                end
                r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_src  <= '0;
        end else begin
            r_out_vld <= w_pop_any;
            if (w_pop_any) begin
                r_out_data <= w_head;
                r_out_src  <= gnt_idx;
            end
        end
    end

    assign out_vld  = r_out_vld;
    assign out_data = r_out_data;
    assign out_src  = r_out_src;

`ifdef REQ_GNT_ERR_EN
    logic w_gnt_bad;
    logic r_gnt_err;
    logic r_gnt_err_sticky;

    // Any valid grant that did not pop was illegal (bad index or empty FIFO).
    assign w_gnt_bad = gnt_vld && !w_pop_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt_err        <= 1'b0;
            r_gnt_err_sticky <= 1'b0;
        end else begin
            r_gnt_err <= w_gnt_bad;
            if (w_gnt_bad) begin
                r_gnt_err_sticky <= 1'b1;
            end
        end
    end

    assign gnt_err        = r_gnt_err;
    assign gnt_err_sticky = r_gnt_err_sticky;
`endif

endmodule
